// File: rtl/l5_pkg.sv
// Shared types and constants for the output-layer MAC sequencer.
// Provides the FSM state enum, default sizes and the ReLU helper.
package l5_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
        DRAIN,
        BIAS,
        CMP,
        TX,
        WAIT_TX
    } state_t;

    localparam int N_CLASS_D = 10;
    localparam int N_GROUP_D = 4;
    localparam int SCORE_W   = 36;
    localparam int TX_W      = 8;
    localparam int CLS_W     = 4;

    function automatic logic signed [SCORE_W-1:0] relu(
        input logic signed [SCORE_W-1:0] s
    );
        return (s > 0) ? s : '0;
    endfunction

endpackage

// File: rtl/l5_argmax.sv
// Running ReLU'd argmax over class scores.
// Ports: clk, rst_n, clr (new run), cmp_en (score valid),
//        score, cls (current class), best_idx (winning class).
module l5_argmax
    import l5_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      cmp_en,
    input  logic signed [SCORE_W-1:0] score,
    input  logic [CLS_W-1:0]          cls,
    output logic [CLS_W-1:0]          best_idx
);

    logic signed [SCORE_W-1:0] best_val;
    logic signed [SCORE_W-1:0] r;

    assign r = relu(score);

    // Strict compare keeps the lower index on ties; starting
    // from zero makes an all-nonpositive run pick class 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (clr) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (cmp_en && (r > best_val)) begin
            best_val <= r;
            best_idx <= cls;
        end
    end

endmodule

// File: rtl/l5_sched.sv
// Output-layer MAC sequencer: ROM addressing, accumulator
// control, argmax tracking and UART hand-off of the winner.
// Ports: clk, rst_n, strt | act_addr, w_addr, b_addr,
//        mac_clr, mac_en, bias_en | score | trmt, tx_data,
//        tx_done | busy, done.
module l5_sched
    import l5_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_D,
    parameter int N_GROUP = N_GROUP_D,
    parameter int ROM_LAT = 1,
    parameter int AW      = 6,
    localparam int GW = (N_GROUP > 1) ? $clog2(N_GROUP) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      strt,
    output logic [GW-1:0]             act_addr,
    output logic [AW-1:0]             w_addr,
    output logic [3:0]                b_addr,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic                      bias_en,
    input  logic signed [SCORE_W-1:0] score,
    output logic                      trmt,
    output logic [TX_W-1:0]           tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      done
);

    localparam int DW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    state_t             state;
    state_t             state_n;
    logic [CLS_W-1:0]   cls;
    logic [GW-1:0]      grp;
    logic [DW-1:0]      dcnt;
    logic [ROM_LAT-1:0] rd_pipe;
    logic               rd_valid;
    logic               start;
    logic               cmp_en;
    logic               last_grp;
    logic               last_cls;
    logic               tx_ack;
    logic [CLS_W-1:0]   best_idx;

    assign last_grp = (grp == GW'(N_GROUP - 1));
    assign last_cls = (cls == CLS_W'(N_CLASS - 1));
    assign tx_ack   = (state == WAIT_TX) && tx_done;

    always_comb begin
        state_n  = state;
        rd_valid = 1'b0;
        mac_clr  = 1'b0;
        bias_en  = 1'b0;
        trmt     = 1'b0;
        start    = 1'b0;
        cmp_en   = 1'b0;
        case (state)
            IDLE: begin
                if (strt) begin
                    start   = 1'b1;
                    state_n = CLR;
                end
            end
            CLR: begin
                mac_clr = 1'b1;
                state_n = ACC;
            end
            ACC: begin
                rd_valid = 1'b1;
                if (last_grp) state_n = DRAIN;
            end
            // ROM_LAT+1 cycles: last product lands, then the
            // accumulator register settles.
            DRAIN: begin
                if (dcnt == DW'(ROM_LAT)) state_n = BIAS;
            end
            BIAS: begin
                bias_en = 1'b1;
                state_n = CMP;
            end
            CMP: begin
                cmp_en  = 1'b1;
                state_n = last_cls ? TX : CLR;
            end
            TX: begin
                trmt    = 1'b1;
                state_n = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cls   <= '0;
            grp   <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= tx_ack;
            if (start) begin
                cls  <= '0;
                busy <= 1'b1;
            end else if (cmp_en && !last_cls) begin
                cls <= cls + 1'b1;
            end
            if (tx_ack) busy <= 1'b0;
            if (state == CLR) begin
                grp <= '0;
            end else if (state == ACC) begin
                grp <= last_grp ? '0 : grp + 1'b1;
            end
            if (state == DRAIN) dcnt <= dcnt + 1'b1;
            else                dcnt <= '0;
        end
    end

    // Read-valid delay line matching the ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_valid;
            for (int i = 1; i < ROM_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign mac_en   = rd_pipe[ROM_LAT-1];
    assign act_addr = grp;
    assign b_addr   = cls;
    assign w_addr   = AW'(cls) * AW'(N_GROUP) + AW'(grp);
    // best_idx only clears on start, so this holds to next strt.
    assign tx_data  = {{(TX_W - CLS_W){1'b0}}, best_idx};

    l5_argmax u_argmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start),
        .cmp_en   (cmp_en),
        .score    (score),
        .cls      (cls),
        .best_idx (best_idx)
    );

endmodule

// File: tb/tb_l5_sched.sv
// Scoreboard bench for l5_sched: address/strobe sequencing,
// argmax result, handshake timing and reset behaviour.
module tb_l5_sched;

    localparam int NC = 10;
    localparam int NG = 4;
    localparam int RL = 1;
    localparam int AW = 6;
    localparam int P  = NG + RL + 4;
    localparam int T_TRMT = 1 + NC * P;

    logic               clk;
    logic               rst_n;
    logic               strt;
    logic [1:0]         act_addr;
    logic [AW-1:0]      w_addr;
    logic [3:0]         b_addr;
    logic               mac_clr;
    logic               mac_en;
    logic               bias_en;
    logic signed [35:0] score;
    logic               trmt;
    logic [7:0]         tx_data;
    logic               tx_done;
    logic               busy;
    logic               done;

    logic signed [35:0] sc_tab [16];

    int n_vec = 0;
    int n_err = 0;
    int n_mac, n_clr, n_bias, n_trmt;
    bit mon_on = 0;

    logic [AW-1:0] wq  [$];
    logic [1:0]    aq  [$];
    logic [7:0]    txq [$];
    logic [AW-1:0] wh  [4];
    logic [1:0]    ah  [4];

    l5_sched #(
        .N_CLASS (NC),
        .N_GROUP (NG),
        .ROM_LAT (RL),
        .AW      (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strt     (strt),
        .act_addr (act_addr),
        .w_addr   (w_addr),
        .b_addr   (b_addr),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .bias_en  (bias_en),
        .score    (score),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: biased score of the addressed class.
    always_comb score = sc_tab[b_addr];

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (mac_en) begin
                n_mac++;
                if (wq.size() == 0) begin
                    chk("mac_en_unexp", mac_en, 0);
                end else begin
                    chk("w_addr", wh[RL-1], wq.pop_front());
                    chk("act_addr", ah[RL-1], aq.pop_front());
                end
            end
            if (mac_clr) n_clr++;
            if (bias_en) n_bias++;
            if (trmt) begin
                n_trmt++;
                if (txq.size() == 0) chk("trmt_unexp", trmt, 0);
                else chk("tx_data", tx_data, txq.pop_front());
            end
        end
        for (int i = 3; i > 0; i--) begin
            wh[i] = wh[i-1];
            ah[i] = ah[i-1];
        end
        wh[0] = w_addr;
        ah[0] = act_addr;
    end

    task automatic chk_idle(input string p);
        chk({p, "_mac_en"}, mac_en, 0);
        chk({p, "_mac_clr"}, mac_clr, 0);
        chk({p, "_bias_en"}, bias_en, 0);
        chk({p, "_trmt"}, trmt, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_w_addr"}, w_addr, 0);
        chk({p, "_act_addr"}, act_addr, 0);
        chk({p, "_b_addr"}, b_addr, 0);
        chk({p, "_tx_data"}, tx_data, 0);
    endtask

    // mode 0: tx_done pulse txd cycles after trmt
    // mode 1: tx_done held high from before trmt
    task automatic run(input int mode, input int txd,
                       input logic [7:0] exp_idx,
                       input bit noise);
        int kt;
        int exp_k;
        bit fin;
        kt  = -1;
        fin = 0;
        n_mac = 0; n_clr = 0; n_bias = 0; n_trmt = 0;
        wq.delete(); aq.delete(); txq.delete();
        for (int c = 0; c < NC; c++) begin
            for (int g = 0; g < NG; g++) begin
                wq.push_back(AW'(c * NG + g));
                aq.push_back(2'(g));
            end
        end
        txq.push_back(exp_idx);
        mon_on = 1;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(posedge clk);
            #1;
            strt = (k == 0) || (noise && (k == 5 || k == 40
                   || (kt >= 0 && k == kt + 3)));
            if (mode == 1) tx_done = (k >= T_TRMT - 5);
            else tx_done = (kt >= 0 && k == kt + txd);
            @(negedge clk);
            if (k == 1) chk("busy_start", busy, 1);
            if (trmt && kt < 0) begin
                kt = k;
                chk("trmt_cycle", k, T_TRMT);
            end
            if (done) begin
                exp_k = (mode == 1) ? kt + 2 : kt + txd + 1;
                chk("done_cycle", k, exp_k);
                chk("busy_at_done", busy, 0);
                fin = 1;
            end
        end
        if (!fin) chk("done_timeout", fin, 1);
        @(posedge clk);
        #1;
        strt    = 0;
        tx_done = 0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("tx_hold", tx_data, exp_idx);
        mon_on = 0;
        chk("n_mac_en", n_mac, NC * NG);
        chk("n_mac_clr", n_clr, NC);
        chk("n_bias_en", n_bias, NC);
        chk("n_trmt", n_trmt, 1);
        chk("addr_left", wq.size(), 0);
        chk("tx_left", txq.size(), 0);
    endtask

    initial begin
        int t1 [10] = '{-5, 3, 7, 7, 2, 0, 1, 6, -1, 4};
        rst_n   = 0;
        strt    = 0;
        tx_done = 0;
        for (int i = 0; i < 16; i++) sc_tab[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int i = 0; i < NC; i++) sc_tab[i] = t1[i];
        run(0, 20, 8'h02, 0);

        for (int i = 0; i < NC; i++) begin
            sc_tab[i] = -36'(i + 1) * 1000;
        end
        run(0, 7, 8'h00, 0);

        for (int i = 0; i < NC - 1; i++) begin
            sc_tab[i] = 36'($urandom_range(1, 1000));
        end
        sc_tab[NC-1] = 36'h7_FFFF_FFFF;
        run(0, 20, 8'h09, 1);

        for (int i = 0; i < NC; i++) sc_tab[i] = t1[i];
        run(1, 0, 8'h02, 0);

        // Abort mid-ACC of class 4, then a fresh full pass.
        @(posedge clk);
        #1;
        strt = 1;
        @(posedge clk);
        #1;
        strt = 0;
        repeat (4 * P + 1) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_cls", b_addr, 4);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        #2;
        chk_idle("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1;
        sc_tab[5] = 50;
        run(0, 4, 8'h05, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

endmodule
